// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR step front-end: data width, mode
// encoding, default debounce lengths and a wrapping counter helper.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Mode switch encoding
    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_LOAD  = 1'b1;

    // Debounce lengths: short for simulation, ~10 ms at 100 MHz for the board
    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 1_000_000;
    localparam int DB_CNT_W_DEF    = 20;

    // Step counter increment, wraps 255 -> 0 on purpose (display only)
    function automatic logic [LFSR_W-1:0] cnt_inc(input logic [LFSR_W-1:0] c);
        return c + LFSR_W'(1);
    endfunction

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// Switch inputs and strobe/status outputs of the LFSR step front-end.
// slave = the controller, master = whoever drives the switches.
interface lfsr_step_ctrl_if;

    logic                        sw_step;
    logic                        sw_mode;
    logic [lfsr_pkg::LFSR_W-1:0] sw_seed;
    logic                        step_pulse;
    logic                        load_pulse;
    logic [lfsr_pkg::LFSR_W-1:0] seed_q;
    logic [lfsr_pkg::LFSR_W-1:0] step_cnt;

    modport slave (
        input  sw_step, sw_mode, sw_seed,
        output step_pulse, load_pulse, seed_q, step_cnt
    );

    modport master (
        output sw_step, sw_mode, sw_seed,
        input  step_pulse, load_pulse, seed_q, step_cnt
    );

endinterface

// File: rtl/lfsr_step_ctrl_sw_debounce.sv
// Single switch channel: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle strobe registered on the edge where
// the debounced level rises.
module sw_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int DB_CNT_W  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    logic                sync1_q;
    logic                sync2_q;
    logic                stable_q;
    logic                stable_d;
    logic                rise_q;
    logic                rise_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    // Accept a new level only after DB_CYCLES consecutive differing samples
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    // Synchroniser, counter, debounced level and rise strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// LFSR step front-end: debounces the step and mode switches, syncs the
// seed, and turns each debounced step press into a one-cycle step_pulse
// (shift mode) or load_pulse with seed capture (load mode).
// Optional macro LFSR_STEP_AUTOREPEAT_EN adds auto-repeat stepping while
// the step switch is held in shift mode.
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_SIM,
    parameter int DB_CNT_W      = DB_CNT_W_DEF,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    lfsr_step_ctrl_if.slave  bus
);

    logic              step_stable_s;
    logic              step_rise_s;
    logic              mode_stable_s;
    logic              mode_rise_unused_s;
    logic              repeat_fire_s;
    logic [LFSR_W-1:0] seed_meta_q;
    logic [LFSR_W-1:0] seed_sync_q;
    logic              step_pulse_q, step_pulse_d;
    logic              load_pulse_q, load_pulse_d;
    logic [LFSR_W-1:0] seed_cap_q, seed_cap_d;
    logic [LFSR_W-1:0] step_cnt_q, step_cnt_d;

    sw_debounce #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_step (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (bus.sw_step),
        .stable_o (step_stable_s),
        .rise_o   (step_rise_s)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_db_mode (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (bus.sw_mode),
        .stable_o (mode_stable_s),
        .rise_o   (mode_rise_unused_s)
    );

`ifdef LFSR_STEP_AUTOREPEAT_EN
    logic        armed_q, armed_d;
    logic [15:0] hold_q, hold_d;

    // Hold timer: first repeat REPEAT_DELAY cycles after the press pulse,
    // then every REPEAT_PERIOD; cancelled by release or load mode
    always_comb begin
        armed_d       = armed_q;
        hold_d        = hold_q;
        repeat_fire_s = 1'b0;
        if (!step_stable_s || (mode_stable_s == MODE_LOAD)) begin
            armed_d = 1'b0;
            hold_d  = 16'd0;
        end else if (step_rise_s) begin
            armed_d = 1'b1;
            hold_d  = 16'd0;
        end else if (armed_q) begin
            if (hold_q == 16'(REPEAT_DELAY - 1)) begin
                repeat_fire_s = 1'b1;
                hold_d        = 16'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                hold_d = hold_q + 16'd1;
            end
        end else begin
            hold_d = 16'd0;
        end
    end

    // Hold timer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            hold_q  <= 16'd0;
        end else begin
            armed_q <= armed_d;
            hold_q  <= hold_d;
        end
    end
`else
    localparam int REPEAT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
    assign repeat_fire_s = 1'b0;
`endif

    // Press action: mode sampled at the debounced edge picks load vs step
    always_comb begin
        step_pulse_d = 1'b0;
        load_pulse_d = 1'b0;
        seed_cap_d   = seed_cap_q;
        step_cnt_d   = step_cnt_q;
        if (step_rise_s) begin
            if (mode_stable_s == MODE_LOAD) begin
                load_pulse_d = 1'b1;
                seed_cap_d   = seed_sync_q;
                step_cnt_d   = LFSR_W'(0);
            end else begin
                step_pulse_d = 1'b1;
                step_cnt_d   = cnt_inc(step_cnt_q);
            end
        end else if (repeat_fire_s) begin
            step_pulse_d = 1'b1;
            step_cnt_d   = cnt_inc(step_cnt_q);
        end else begin
            step_pulse_d = 1'b0;
        end
    end

    // Seed synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_meta_q  <= '0;
            seed_sync_q  <= '0;
            step_pulse_q <= 1'b0;
            load_pulse_q <= 1'b0;
            seed_cap_q   <= '0;
            step_cnt_q   <= '0;
        end else begin
            seed_meta_q  <= bus.sw_seed;
            seed_sync_q  <= seed_meta_q;
            step_pulse_q <= step_pulse_d;
            load_pulse_q <= load_pulse_d;
            seed_cap_q   <= seed_cap_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.seed_q     = seed_cap_q;
    assign bus.step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Bench for lfsr_step_ctrl (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Honours LFSR_STEP_AUTOREPEAT_EN for the held-switch scenario.
module tb_lfsr_step_ctrl;
    import lfsr_pkg::*;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lfsr_step_ctrl_if bus();

    lfsr_step_ctrl #(
        .DB_CYCLES(DB), .DB_CNT_W(20), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_step = 0;
    int n_load = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: delay lines, sample windows, debounced levels
    bit          m_st_pipe[2];
    bit          m_md_pipe[2];
    logic [7:0]  m_seed_pipe[2];
    logic [DB-1:0] m_st_hist, m_md_hist;
    int          m_st_fill, m_md_fill;
    bit          m_st_stable, m_md_stable, m_rise_pending;
    bit          e_step, e_load;
    logic [7:0]  e_seed, e_cnt;
    int          m_edge;
    bit          m_armed;
    int          m_next;

    // A level flips once the last DB visible samples all disagree with it
    function automatic bit window_flips(input logic [DB-1:0] hist, input int fill, input bit lvl);
        return (fill >= DB) && (hist == (lvl ? {DB{1'b0}} : {DB{1'b1}}));
    endfunction

    task automatic model_reset();
        m_st_pipe = '{0, 0}; m_md_pipe = '{0, 0}; m_seed_pipe = '{8'h00, 8'h00};
        m_st_hist = '0; m_md_hist = '0; m_st_fill = 0; m_md_fill = 0;
        m_st_stable = 0; m_md_stable = 0; m_rise_pending = 0;
        e_step = 0; e_load = 0; e_seed = 8'h00; e_cnt = 8'h00;
        m_edge = 0; m_armed = 0; m_next = 0;
    endtask

    task automatic model_edge();
        m_edge++;
        e_step = 0;
        e_load = 0;
        if (m_rise_pending) begin
            if (m_md_stable) begin
                e_load = 1; e_seed = m_seed_pipe[1]; e_cnt = 8'h00;
            end else begin
                e_step = 1; e_cnt = e_cnt + 8'h01;
            end
        end
`ifdef LFSR_STEP_AUTOREPEAT_EN
        if (!m_st_stable || m_md_stable) begin
            m_armed = 0;
        end else if (m_rise_pending) begin
            m_armed = 1; m_next = m_edge + RD;
        end else if (m_armed && m_edge == m_next) begin
            e_step = 1; e_cnt = e_cnt + 8'h01; m_next = m_edge + RP;
        end
`endif
        m_st_hist = {m_st_hist[DB-2:0], m_st_pipe[1]};
        m_md_hist = {m_md_hist[DB-2:0], m_md_pipe[1]};
        if (m_st_fill < DB) m_st_fill++;
        if (m_md_fill < DB) m_md_fill++;
        m_rise_pending = 0;
        if (window_flips(m_st_hist, m_st_fill, m_st_stable)) begin
            m_st_stable = !m_st_stable;
            m_rise_pending = m_st_stable;
        end
        if (window_flips(m_md_hist, m_md_fill, m_md_stable)) m_md_stable = !m_md_stable;
        m_st_pipe[1] = m_st_pipe[0];     m_st_pipe[0] = bus.sw_step;
        m_md_pipe[1] = m_md_pipe[0];     m_md_pipe[0] = bus.sw_mode;
        m_seed_pipe[1] = m_seed_pipe[0]; m_seed_pipe[0] = bus.sw_seed;
    endtask

    // One clock: advance model at the edge, compare outputs at the falling edge
    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        @(negedge clk);
        check_val("step_pulse", {31'd0, bus.step_pulse}, {31'd0, e_step});
        check_val("load_pulse", {31'd0, bus.load_pulse}, {31'd0, e_load});
        check_val("seed_q", {24'd0, bus.seed_q}, {24'd0, e_seed});
        check_val("step_cnt", {24'd0, bus.step_cnt}, {24'd0, e_cnt});
        check_val("pulse_excl", {31'd0, bus.step_pulse & bus.load_pulse}, 32'd0);
        if (bus.step_pulse) n_step++;
        if (bus.load_pulse) n_load++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Hold step high for n cycles; report first pulse cycle and pulse count
    task automatic press(input int n, output int first, output int pulses);
        first = -1;
        pulses = 0;
        bus.sw_step = 1'b1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.step_pulse || bus.load_pulse) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    int first, pulses, s_step, s_load;
    int offs[$];
`ifdef LFSR_STEP_AUTOREPEAT_EN
    int exp_offs[7] = '{0, 8, 12, 16, 20, 24, 28};
`endif

    initial begin
        bus.sw_step = 1'b0;
        bus.sw_mode = 1'b0;
        bus.sw_seed = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_step_pulse", {31'd0, bus.step_pulse}, 32'd0);
        check_val("rst_load_pulse", {31'd0, bus.load_pulse}, 32'd0);
        check_val("rst_seed_q", {24'd0, bus.seed_q}, 32'd0);
        check_val("rst_step_cnt", {24'd0, bus.step_cnt}, 32'd0);
        rst = 1'b1;
        run(5);

        // Single press in shift mode
        s_load = n_load;
        press(10, first, pulses);
        check_val("t1_first_edge", first, DB + 3);
        check_val("t1_pulses", pulses, 1);
        check_val("t1_cnt", {24'd0, bus.step_cnt}, 32'd1);
        check_val("t1_no_load", n_load - s_load, 0);
        bus.sw_step = 1'b0;
        run(10);

        // Glitch shorter than the debounce window
        s_step = n_step;
        bus.sw_step = 1'b1;
        run(DB - 1);
        bus.sw_step = 1'b0;
        run(10);
        check_val("t2_no_pulse", n_step - s_step, 0);
        check_val("t2_cnt", {24'd0, bus.step_cnt}, 32'd1);

        // Load with seed A5, then seed changes without a press
        bus.sw_seed = 8'hA5;
        bus.sw_mode = 1'b1;
        run(10);
        s_step = n_step;
        s_load = n_load;
        press(10, first, pulses);
        bus.sw_step = 1'b0;
        run(10);
        check_val("t3_load_once", n_load - s_load, 1);
        check_val("t3_no_step", n_step - s_step, 0);
        check_val("t3_seed", {24'd0, bus.seed_q}, 32'hA5);
        check_val("t3_cnt", {24'd0, bus.step_cnt}, 32'd0);
        bus.sw_seed = 8'h3C;
        run(10);
        check_val("t3_seed_hold", {24'd0, bus.seed_q}, 32'hA5);
        bus.sw_mode = 1'b0;
        run(10);

        // 256 shift presses wrap the counter back to zero
        s_step = n_step;
        for (int p = 1; p <= 256; p++) begin
            bus.sw_step = 1'b1;
            run(5);
            bus.sw_step = 1'b0;
            run(5);
            if (p == 1) check_val("t4_cnt_1", {24'd0, bus.step_cnt}, 32'd1);
            if (p == 255) check_val("t4_cnt_255", {24'd0, bus.step_cnt}, 32'hFF);
        end
        check_val("t4_cnt_wrap", {24'd0, bus.step_cnt}, 32'd0);
        check_val("t4_pulses", n_step - s_step, 256);

        // Reset while step is held: one fresh pulse after release
        press(10, first, pulses);
        rst = 1'b0;
        run(3);
        check_val("t5_rst_step", {31'd0, bus.step_pulse}, 32'd0);
        check_val("t5_rst_cnt", {24'd0, bus.step_cnt}, 32'd0);
        check_val("t5_rst_seed", {24'd0, bus.seed_q}, 32'd0);
        rst = 1'b1;
        press(12, first, pulses);
        check_val("t5_first_edge", first, DB + 3);
        check_val("t5_pulses", pulses, 1);
        check_val("t5_cnt", {24'd0, bus.step_cnt}, 32'd1);
        bus.sw_step = 1'b0;
        run(10);

        // Held press in shift mode (load first to zero the counter)
        bus.sw_mode = 1'b1;
        run(8);
        press(10, first, pulses);
        bus.sw_step = 1'b0;
        run(10);
        bus.sw_mode = 1'b0;
        run(8);
        check_val("t6_cnt_zero", {24'd0, bus.step_cnt}, 32'd0);
        first = -1;
        offs.delete();
        bus.sw_step = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.step_pulse) begin
                if (first < 0) first = i;
                offs.push_back(i - first);
            end
            if (first >= 0 && i - first >= 30) break;
        end
        check_val("t6_first_edge", first, DB + 3);
`ifdef LFSR_STEP_AUTOREPEAT_EN
        check_val("t6_npulses", offs.size(), 7);
        for (int k = 0; k < 7; k++)
            if (k < offs.size()) check_val("t6_offset", offs[k], exp_offs[k]);
        check_val("t6_cnt", {24'd0, bus.step_cnt}, 32'd7);
`else
        check_val("t6_npulses", offs.size(), 1);
        check_val("t6_cnt", {24'd0, bus.step_cnt}, 32'd1);
`endif
        bus.sw_mode = 1'b1;
        run(8);
        s_step = n_step;
        run(20);
        check_val("t6_mode_stops", n_step - s_step, 0);
        bus.sw_step = 1'b0;
        bus.sw_mode = 1'b0;
        run(10);

        // Random switch activity
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: bus.sw_step = ~bus.sw_step;
                6, 7:             bus.sw_mode = ~bus.sw_mode;
                default:          bus.sw_seed = 8'($urandom);
            endcase
            run($urandom_range(1, 12));
        end
        bus.sw_step = 1'b0;
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
